// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock divider generator.
package clk_div_pkg;

  // Default divisor width and the divisor every channel wakes up with.
  localparam int unsigned DIV_W_DEFAULT     = 8;
  localparam int unsigned DEFAULT_DIV_VALUE = 2;

  // Divisor value at the default width.
  typedef logic [DIV_W_DEFAULT-1:0] div_t;

endpackage : clk_div_pkg

// File: rtl/clk_div_ch.sv
// One divided-clock channel: period counter, shadow/active divisor pair,
// pending-update flag and the high/low phase compare.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VALUE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             align_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] loadDiv_i,
  output logic             pending_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] activeDiv_q, activeDiv_d;
  logic [DIV_W-1:0] shadowDiv_q, shadowDiv_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             chDisabled;
  logic             lastCnt;
  logic             boundary;
  logic [DIV_W-1:0] highLen;

  // A divisor of 0 or 1 parks the channel; every edge is then a period boundary.
  assign chDisabled = (activeDiv_q <= DIV_W'(1));
  assign lastCnt    = (cnt_q == (activeDiv_q - DIV_W'(1)));
  assign boundary   = chDisabled | lastCnt;
  // High phase is ceil(N/2) counts, so odd divisors get the extra cycle high.
  assign highLen    = activeDiv_q - (activeDiv_q >> 1);

  // Next-state: count/compare, then accept a new shadow value, then align or divisor swap.
  always_comb begin
    activeDiv_d = activeDiv_q;
    shadowDiv_d = shadowDiv_q;
    pending_d   = pending_q;
    cnt_d       = '0;
    clk_d       = 1'b0;
    tick_d      = 1'b0;

    if (!chDisabled) begin
      cnt_d  = lastCnt ? '0 : cnt_q + DIV_W'(1);
      clk_d  = (cnt_q < highLen);
      tick_d = lastCnt;
    end

    if (load_i) begin
      shadowDiv_d = loadDiv_i;
      pending_d   = 1'b1;
    end

    if (align_i) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
    end else if (boundary && pending_q) begin
      activeDiv_d = shadowDiv_q;
      pending_d   = 1'b0;
      cnt_d       = '0;
    end
  end

  // Channel state register with asynchronous return to the default divisor.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      activeDiv_q <= DIV_W'(DEFAULT_DIV);
      shadowDiv_q <= DIV_W'(DEFAULT_DIV);
      pending_q   <= 1'b0;
      cnt_q       <= '0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      activeDiv_q <= activeDiv_d;
      shadowDiv_q <= shadowDiv_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
    end
  end

  assign pending_o = pending_q;
  assign clk_o     = clk_q;
  assign tick_o    = tick_q;

endmodule : clk_div_ch

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider: decodes the shared config bus into per-channel
// load strobes and instantiates one clk_div_ch per output.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VALUE,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              align,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;

  // Config decode: an unmatched channel index reads as ready and loads nothing.
  always_comb begin
    cfg_ready = 1'b1;
    load      = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pending[i];
        load[i]   = cfg_valid & ~pending[i];
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : gCh
    clk_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) uCh (
      .clk_i     (clk_in),
      .rst_ni    (rst_n),
      .align_i   (align),
      .load_i    (load[g]),
      .loadDiv_i (cfg_div),
      .pending_o (pending[g]),
      .clk_o     (clk_out[g]),
      .tick_o    (tick[g])
    );
  end

endmodule : clk_div_gen

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: a behavioural model predicts every
// cycle's clk_out/tick, pushed to a scoreboard when stimulus is driven.
module tb_clk_div_gen;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 2;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              align;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  typedef struct packed {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] tick;
  } exp_t;

  exp_t sbq[$];
  int   nChecks = 0;
  int   nPass   = 0;
  int   nFail   = 0;

  int mN[NUM_CH];
  int mShadow[NUM_CH];
  int mPos[NUM_CH];
  bit mPend[NUM_CH];

  clk_div_gen #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (2)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .align     (align),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // Free-running system clock.
  always #5 clk_in = ~clk_in;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      mN[i] = 2; mShadow[i] = 2; mPos[i] = 0; mPend[i] = 1'b0;
    end
  endfunction

  function automatic bit model_ready(int ch);
    if (ch >= NUM_CH) return 1'b1;
    return !mPend[ch];
  endfunction

  // Position mPos within the period predicts the output the coming edge registers.
  function automatic exp_t model_edge(bit v, int ch, int dv, bit al);
    exp_t e;
    bit   bnd;
    bit   acc;
    e = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bnd = (mN[i] < 2) || (mPos[i] == mN[i] - 1);
      acc = v && (ch == i) && !mPend[i];
      if (al) begin
        mPos[i] = 0;
      end else begin
        if (mN[i] >= 2) begin
          e.clk[i]  = (mPos[i] < (mN[i] + 1) / 2);
          e.tick[i] = bnd;
        end
        mPos[i] = bnd ? 0 : mPos[i] + 1;
        if (bnd && mPend[i]) begin
          mN[i] = mShadow[i]; mPend[i] = 1'b0;
        end
      end
      if (acc) begin
        mShadow[i] = dv; mPend[i] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic drive_cycle(input bit v, input int ch, input int dv, input bit al);
    cfg_valid = v;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
    align     = al;
    sbq.push_back(model_edge(v, ch, dv, al));
    @(posedge clk_in); #1;
    cfg_valid = 1'b0;
    align     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; align = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    nChecks++;
    if (clk_out !== 4'h0) begin nFail++; $display("[TB] FAIL reset_clk: got %b, expected 0000", clk_out); end else nPass++;
    nChecks++;
    if (tick !== 4'h0) begin nFail++; $display("[TB] FAIL reset_tick: got %b, expected 0000", tick); end else nPass++;
    nChecks++;
    if (cfg_ready !== 1'b1) begin nFail++; $display("[TB] FAIL reset_ready: got %b, expected 1", cfg_ready); end else nPass++;
    rst_n = 1'b1;
  endtask

  task automatic test_defaults();
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, 0, 0, 1'b0);
      e = sbq.pop_front();
      nChecks++;
      if ({clk_out, tick} !== e) begin
        nFail++; $display("[TB] FAIL defaults cyc%0d: clk_out=%b tick=%b, expected clk_out=%b tick=%b", k, clk_out, tick, e.clk, e.tick);
      end else nPass++;
      if (k == 0) begin
        nChecks++;
        if (clk_out !== 4'hF) begin nFail++; $display("[TB] FAIL defaults_first_high: got %b, expected 1111", clk_out); end else nPass++;
      end
      if (k == 1) begin
        nChecks++;
        if (tick !== 4'hF) begin nFail++; $display("[TB] FAIL defaults_tick: got %b, expected 1111", tick); end else nPass++;
      end
    end
  endtask

  task automatic test_load_ch1();
    exp_t e;
    cfg_ch = 2'd1; #1;
    nChecks++;
    if (cfg_ready !== model_ready(1)) begin nFail++; $display("[TB] FAIL ch1_ready: got %b, expected %b", cfg_ready, model_ready(1)); end else nPass++;
    for (int k = 0; k < 17; k++) begin
      drive_cycle(k == 0, 1, 5, 1'b0);
      e = sbq.pop_front();
      nChecks++;
      if ({clk_out, tick} !== e) begin
        nFail++; $display("[TB] FAIL ch1_n5 cyc%0d: clk_out=%b tick=%b, expected clk_out=%b tick=%b", k, clk_out, tick, e.clk, e.tick);
      end else nPass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   rdy;
    bit   sent;
    cfg_ch = 2'd0; #1;
    nChecks++;
    if (cfg_ready !== model_ready(0)) begin nFail++; $display("[TB] FAIL b2b_ready_first: got %b, expected %b", cfg_ready, model_ready(0)); end else nPass++;
    drive_cycle(1'b1, 0, 3, 1'b0);
    e = sbq.pop_front();
    nChecks++;
    if ({clk_out, tick} !== e) begin
      nFail++; $display("[TB] FAIL b2b_load3: clk_out=%b tick=%b, expected clk_out=%b tick=%b", clk_out, tick, e.clk, e.tick);
    end else nPass++;
    nChecks++;
    if (cfg_ready !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_busy: got %b, expected 0", cfg_ready); end else nPass++;
    sent = 1'b0;
    for (int k = 0; k < 24; k++) begin
      cfg_ch = 2'd0; #1;
      rdy = model_ready(0);
      nChecks++;
      if (cfg_ready !== rdy) begin nFail++; $display("[TB] FAIL b2b_ready cyc%0d: got %b, expected %b", k, cfg_ready, rdy); end else nPass++;
      drive_cycle(!sent, 0, 6, 1'b0);
      if (!sent && rdy) sent = 1'b1;
      e = sbq.pop_front();
      nChecks++;
      if ({clk_out, tick} !== e) begin
        nFail++; $display("[TB] FAIL b2b cyc%0d: clk_out=%b tick=%b, expected clk_out=%b tick=%b", k, clk_out, tick, e.clk, e.tick);
      end else nPass++;
    end
    nChecks++;
    if (!sent) begin nFail++; $display("[TB] FAIL b2b_timeout: second request accepted=0, expected 1"); end else nPass++;
  endtask

  task automatic test_disable();
    exp_t e;
    int   dv;
    for (int k = 0; k < 16; k++) begin
      dv = (k < 5) ? 0 : 4;
      if (k == 0 || k == 5) begin
        cfg_ch = 2'd2; #1;
        nChecks++;
        if (cfg_ready !== model_ready(2)) begin nFail++; $display("[TB] FAIL dis_ready cyc%0d: got %b, expected %b", k, cfg_ready, model_ready(2)); end else nPass++;
      end
      drive_cycle(k == 0 || k == 5, 2, dv, 1'b0);
      e = sbq.pop_front();
      nChecks++;
      if ({clk_out, tick} !== e) begin
        nFail++; $display("[TB] FAIL disable cyc%0d: clk_out=%b tick=%b, expected clk_out=%b tick=%b", k, clk_out, tick, e.clk, e.tick);
      end else nPass++;
      if (k == 4) begin
        nChecks++;
        if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin nFail++; $display("[TB] FAIL disable_held: clk=%b tick=%b, expected 0 0", clk_out[2], tick[2]); end else nPass++;
      end
    end
  endtask

  task automatic test_align();
    exp_t e;
    bit   rdy;
    bit   sent;
    int   chs[3];
    int   dvs[3];
    chs = '{0, 1, 2};
    dvs = '{3, 4, 6};
    for (int j = 0; j < 3; j++) begin
      sent = 1'b0;
      for (int k = 0; k < 12 && !sent; k++) begin
        cfg_ch = CH_W'(chs[j]); #1;
        rdy = model_ready(chs[j]);
        nChecks++;
        if (cfg_ready !== rdy) begin nFail++; $display("[TB] FAIL align_ready ch%0d: got %b, expected %b", chs[j], cfg_ready, rdy); end else nPass++;
        drive_cycle(1'b1, chs[j], dvs[j], 1'b0);
        if (rdy) sent = 1'b1;
        e = sbq.pop_front();
        nChecks++;
        if ({clk_out, tick} !== e) begin
          nFail++; $display("[TB] FAIL align_load ch%0d: clk_out=%b tick=%b, expected clk_out=%b tick=%b", chs[j], clk_out, tick, e.clk, e.tick);
        end else nPass++;
      end
      nChecks++;
      if (!sent) begin nFail++; $display("[TB] FAIL align_load_timeout ch%0d: accepted=0, expected 1", chs[j]); end else nPass++;
    end
    for (int k = 0; k < 28; k++) begin
      drive_cycle(1'b0, 0, 0, k == 15);
      e = sbq.pop_front();
      nChecks++;
      if ({clk_out, tick} !== e) begin
        nFail++; $display("[TB] FAIL align cyc%0d: clk_out=%b tick=%b, expected clk_out=%b tick=%b", k, clk_out, tick, e.clk, e.tick);
      end else nPass++;
      if (k == 15) begin
        nChecks++;
        if ({clk_out, tick} !== 8'h00) begin nFail++; $display("[TB] FAIL align_zero: clk_out=%b tick=%b, expected 0000 0000", clk_out, tick); end else nPass++;
      end
      if (k == 16) begin
        nChecks++;
        if (clk_out !== 4'hF) begin nFail++; $display("[TB] FAIL align_rise: got %b, expected 1111", clk_out); end else nPass++;
      end
    end
  endtask

  task automatic test_reset_pending();
    exp_t e;
    cfg_ch = 2'd3; #1;
    nChecks++;
    if (cfg_ready !== model_ready(3)) begin nFail++; $display("[TB] FAIL rstp_ready: got %b, expected %b", cfg_ready, model_ready(3)); end else nPass++;
    drive_cycle(1'b1, 3, 7, 1'b0);
    e = sbq.pop_front();
    nChecks++;
    if ({clk_out, tick} !== e) begin
      nFail++; $display("[TB] FAIL rstp_load: clk_out=%b tick=%b, expected clk_out=%b tick=%b", clk_out, tick, e.clk, e.tick);
    end else nPass++;
    #2;
    nChecks++;
    if (cfg_ready !== 1'b0) begin nFail++; $display("[TB] FAIL rstp_pending: got %b, expected 0", cfg_ready); end else nPass++;
    rst_n = 1'b0;
    #1;
    model_reset();
    nChecks++;
    if ({clk_out, tick} !== 8'h00) begin nFail++; $display("[TB] FAIL rstp_async: clk_out=%b tick=%b, expected 0000 0000", clk_out, tick); end else nPass++;
    nChecks++;
    if (cfg_ready !== 1'b1) begin nFail++; $display("[TB] FAIL rstp_cleared: got %b, expected 1", cfg_ready); end else nPass++;
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b0, 0, 0, 1'b0);
      e = sbq.pop_front();
      nChecks++;
      if ({clk_out, tick} !== e) begin
        nFail++; $display("[TB] FAIL rstp_resume cyc%0d: clk_out=%b tick=%b, expected clk_out=%b tick=%b", k, clk_out, tick, e.clk, e.tick);
      end else nPass++;
      if (k == 0) begin
        nChecks++;
        if (clk_out[3] !== 1'b1) begin nFail++; $display("[TB] FAIL rstp_first_high: got %b, expected 1", clk_out[3]); end else nPass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_load_ch1();
    test_back_to_back();
    test_disable();
    test_align();
    test_reset_pending();
    nChecks++;
    if (sbq.size() != 0) begin nFail++; $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", sbq.size()); end else nPass++;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule : tb_clk_div_gen
